input_hub: RTL and testbench

Parametrised per-player input capture block between `hps_io` and the test system CPU. It takes the live joystick, left-analog and spinner buses for N players and keeps three things per player: a coherent frame snapshot, sticky press-edge masks, and a wrapping spinner position accumulator. The CPU reads all of it through a byte-wide, one-cycle-latency register port, so software no longer samples raw buses or computes edges itself.

---
 rtl/input_hub_pkg.sv | 20 ++
 rtl/input_hub_chan.sv | 66 ++++++
 rtl/input_hub.sv | 127 ++++++++++++
 tb/tb_input_hub.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_hub_pkg.sv
// Shared register map, accumulator width and accumulator type for input_hub.
package input_hub_pkg;

    localparam int ACC_W = 16;

    typedef logic [ACC_W-1:0] acc_t;

    // Per-player byte offsets (low nibble of cpu_addr)
    localparam logic [3:0] REG_JOY      = 4'd0;
    localparam logic [3:0] REG_PRESS    = 4'd4;
    localparam logic [3:0] REG_ANA_X    = 4'd8;
    localparam logic [3:0] REG_ANA_Y    = 4'd9;
    localparam logic [3:0] REG_ACC_LO   = 4'd10;
    localparam logic [3:0] REG_ACC_HI   = 4'd11;
    localparam logic [3:0] REG_SNAP_LO  = 4'd12;
    localparam logic [3:0] REG_SNAP_HI  = 4'd13;
    localparam logic [3:0] REG_NPLAYERS = 4'd14;
    localparam logic [3:0] REG_JOYBYTES = 4'd15;

endpackage

// File: rtl/input_hub_chan.sv
// One player channel: priming, sticky press mask, spinner accumulator and
// frame snapshots of joystick, analog stick and accumulator.
module input_hub_chan
    import input_hub_pkg::*;
#(
    parameter int JOY_W = 32
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             snap,
    input  logic [JOY_W-1:0] joy,
    input  logic [15:0]      ana,
    input  logic [8:0]       spin,
    input  logic             clr,
    output logic [JOY_W-1:0] joy_snap,
    output logic [JOY_W-1:0] press,
    output logic [15:0]      ana_snap,
    output acc_t             acc,
    output acc_t             acc_snap
);

    logic             primed;
    logic [JOY_W-1:0] prev_joy;
    logic             prev_tog;
    logic [JOY_W-1:0] press_nxt;
    acc_t             delta;

    // New edges are OR-ed in after the clear so a same-cycle edge survives;
    // nothing counts as an edge until the first post-reset sample is taken.
    always_comb begin
        press_nxt = clr ? '0 : press;
        if (primed) begin
            press_nxt = press_nxt | (joy & ~prev_joy);
        end
    end

    assign delta = {{(ACC_W-8){spin[7]}}, spin[7:0]};

    // Channel state: history, mask, accumulator and snapshot registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            primed   <= 1'b0;
            prev_joy <= '0;
            prev_tog <= 1'b0;
            press    <= '0;
            acc      <= '0;
            joy_snap <= '0;
            ana_snap <= '0;
            acc_snap <= '0;
        end else begin
            primed   <= 1'b1;
            prev_joy <= joy;
            prev_tog <= spin[8];
            press    <= press_nxt;
            if (primed && (spin[8] != prev_tog)) begin
                acc <= acc + delta;
            end
            if (snap) begin
                joy_snap <= joy;
                ana_snap <= ana;
                acc_snap <= acc;
            end
        end
    end

endmodule

// File: rtl/input_hub.sv
// Per-player input capture hub with a byte-wide, one-cycle-latency CPU
// register port. Player channels live in input_hub_chan.
module input_hub #(
    parameter int PLAYERS = 6,
    parameter int JOY_W   = 32,
    parameter int ACC_W   = 16
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     snap,
    input  logic [PLAYERS*JOY_W-1:0] joystick,
    input  logic [PLAYERS*16-1:0]    analog_l,
    input  logic [PLAYERS*9-1:0]     spinner,
    input  logic [7:0]               cpu_addr,
    input  logic                     cpu_rd,
    input  logic                     cpu_clr,
    output logic [7:0]               cpu_dout,
    output logic                     cpu_valid
);

    import input_hub_pkg::*;

    logic [3:0]  rd_player;
    logic [3:0]  rd_reg;
    logic        player_ok;
    logic [7:0]  rd_data;
    logic [7:0]  acc_shadow;
    logic [31:0] joy_sel;
    logic [31:0] press_sel;

    // Channel outputs padded to the full 16-player address space so the
    // read mux can index directly with the player nibble.
    logic [31:0] joy_snap_w [16];
    logic [31:0] press_w    [16];
    logic [15:0] ana_w      [16];
    acc_t        acc_w      [16];
    acc_t        acc_snap_w [16];

    assign rd_player = cpu_addr[7:4];
    assign rd_reg    = cpu_addr[3:0];
    assign player_ok = ({1'b0, rd_player} < 5'(PLAYERS));

    for (genvar p = 0; p < 16; p++) begin : g_player
        if (p < PLAYERS) begin : g_chan
            logic [JOY_W-1:0] js;
            logic [JOY_W-1:0] pr;
            logic             clr_p;

            assign clr_p = cpu_clr && (rd_player == 4'(p));

            input_hub_chan #(
                .JOY_W (JOY_W)
            ) u_chan (
                .clk_sys  (clk_sys),
                .reset    (reset),
                .snap     (snap),
                .joy      (joystick[p*JOY_W +: JOY_W]),
                .ana      (analog_l[p*16 +: 16]),
                .spin     (spinner[p*9 +: 9]),
                .clr      (clr_p),
                .joy_snap (js),
                .press    (pr),
                .ana_snap (ana_w[p]),
                .acc      (acc_w[p]),
                .acc_snap (acc_snap_w[p])
            );

            assign joy_snap_w[p] = 32'(js);
            assign press_w[p]    = 32'(pr);
        end else begin : g_empty
            assign joy_snap_w[p] = '0;
            assign press_w[p]    = '0;
            assign ana_w[p]      = '0;
            assign acc_w[p]      = '0;
            assign acc_snap_w[p] = '0;
        end
    end

    assign joy_sel   = joy_snap_w[rd_player];
    assign press_sel = press_w[rd_player];

    // Register read mux; unpopulated players read as zero.
    always_comb begin
        rd_data = 8'h00;
        if (player_ok) begin
            unique case (rd_reg)
                REG_JOY, REG_JOY + 4'd1, REG_JOY + 4'd2, REG_JOY + 4'd3:
                    rd_data = joy_sel[{rd_reg[1:0], 3'b000} +: 8];
                REG_PRESS, REG_PRESS + 4'd1, REG_PRESS + 4'd2, REG_PRESS + 4'd3:
                    rd_data = press_sel[{rd_reg[1:0], 3'b000} +: 8];
                REG_ANA_X:    rd_data = ana_w[rd_player][7:0];
                REG_ANA_Y:    rd_data = ana_w[rd_player][15:8];
                REG_ACC_LO:   rd_data = acc_w[rd_player][7:0];
                REG_ACC_HI:   rd_data = acc_shadow;
                REG_SNAP_LO:  rd_data = acc_snap_w[rd_player][7:0];
                REG_SNAP_HI:  rd_data = acc_snap_w[rd_player][ACC_W-1 -: 8];
                REG_NPLAYERS: rd_data = 8'(PLAYERS);
                REG_JOYBYTES: rd_data = 8'(JOY_W / 8);
                default:      rd_data = 8'h00;
            endcase
        end
    end

    // Reading the live low byte freezes the high byte so a 16-bit value can
    // be assembled from two byte reads without tearing.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            acc_shadow <= 8'h00;
        end else if (cpu_rd && player_ok && (rd_reg == REG_ACC_LO)) begin
            acc_shadow <= acc_w[rd_player][ACC_W-1 -: 8];
        end
    end

    // Output register: one-cycle read latency, data held between reads.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cpu_dout  <= 8'h00;
            cpu_valid <= 1'b0;
        end else begin
            cpu_valid <= cpu_rd;
            if (cpu_rd) begin
                cpu_dout <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_input_hub.sv
// Self-checking bench for input_hub (PLAYERS=6, JOY_W=32).
module tb_input_hub;

    localparam int NP = 6;
    localparam int JW = 32;

    logic            clk_sys = 1'b0;
    logic            reset;
    logic            snap;
    logic [NP*JW-1:0] joystick;
    logic [NP*16-1:0] analog_l;
    logic [NP*9-1:0]  spinner;
    logic [7:0]      cpu_addr;
    logic            cpu_rd;
    logic            cpu_clr;
    logic [7:0]      cpu_dout;
    logic            cpu_valid;

    int checks = 0;
    int errors = 0;

    input_hub #(.PLAYERS(NP), .JOY_W(JW), .ACC_W(16)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .snap      (snap),
        .joystick  (joystick),
        .analog_l  (analog_l),
        .spinner   (spinner),
        .cpu_addr  (cpu_addr),
        .cpu_rd    (cpu_rd),
        .cpu_clr   (cpu_clr),
        .cpu_dout  (cpu_dout),
        .cpu_valid (cpu_valid)
    );

    always #5 clk_sys = ~clk_sys;

    // Behavioural reference state
    bit          m_primed;
    logic [31:0] m_prev_joy [NP];
    logic        m_prev_tog [NP];
    logic [31:0] m_press    [NP];
    logic [31:0] m_jsnap    [NP];
    logic [15:0] m_asnap    [NP];
    logic [15:0] m_acc      [NP];
    logic [15:0] m_accsnap  [NP];
    logic [7:0]  m_shadow;
    logic [7:0]  m_dout;
    logic        m_valid;

    function automatic logic [7:0] model_read(input logic [7:0] a);
        int p = int'(a[7:4]);
        int r = int'(a[3:0]);
        if (p >= NP) return 8'h00;
        if (r < 4)   return m_jsnap[p] >> (8 * r);
        if (r < 8)   return m_press[p] >> (8 * (r - 4));
        case (r)
            8:  return m_asnap[p][7:0];
            9:  return m_asnap[p][15:8];
            10: return m_acc[p][7:0];
            11: return m_shadow;
            12: return m_accsnap[p][7:0];
            13: return m_accsnap[p][15:8];
            14: return 8'(NP);
            default: return 8'(JW / 8);
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] j;
        logic [8:0]  s;
        if (reset) begin
            m_primed = 0;
            m_shadow = 0;
            m_dout   = 0;
            m_valid  = 0;
            for (int p = 0; p < NP; p++) begin
                m_prev_joy[p] = 0; m_prev_tog[p] = 0; m_press[p] = 0;
                m_jsnap[p] = 0; m_asnap[p] = 0; m_acc[p] = 0; m_accsnap[p] = 0;
            end
            return;
        end
        m_valid = cpu_rd;
        if (cpu_rd) begin
            m_dout = model_read(cpu_addr);
            if (cpu_addr[3:0] == 4'd10 && int'(cpu_addr[7:4]) < NP)
                m_shadow = m_acc[cpu_addr[7:4]][15:8];
        end
        for (int p = 0; p < NP; p++) begin
            j = joystick[p*JW +: JW];
            s = spinner[p*9 +: 9];
            if (snap) begin
                m_jsnap[p]   = j;
                m_asnap[p]   = analog_l[p*16 +: 16];
                m_accsnap[p] = m_acc[p];
            end
            if (cpu_clr && int'(cpu_addr[7:4]) == p) m_press[p] = 0;
            if (m_primed) begin
                m_press[p] = m_press[p] | (j & ~m_prev_joy[p]);
                if (s[8] != m_prev_tog[p])
                    m_acc[p] = 16'(int'(m_acc[p]) + int'($signed(s[7:0])));
            end
            m_prev_joy[p] = j;
            m_prev_tog[p] = s[8];
        end
        m_primed = 1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_sys);
        #1;
        snap    = 0;
        cpu_rd  = 0;
        cpu_clr = 0;
    endtask

    task automatic do_read(input logic [7:0] a, output logic [7:0] d);
        cpu_addr = a;
        cpu_rd   = 1;
        tick();
        d = cpu_dout;
    endtask

    task automatic set_joy(input int p, input logic [31:0] v);
        joystick[p*JW +: JW] = v;
    endtask

    task automatic spin_event(input int p, input logic [7:0] d);
        spinner[p*9 +: 8] = d;
        spinner[p*9 + 8]  = ~spinner[p*9 + 8];
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset = 1;
        set_joy(0, 32'h0000_0010);
        tick(); tick();
        checks++;
        if (cpu_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b want 0", cpu_valid);
        end
        checks++;
        if (cpu_dout !== 8'h00) begin
            errors++; $display("FAIL reset_dout got %02h want 00", cpu_dout);
        end
        reset = 0;
        tick();                       // priming cycle
        do_read(8'h04, d);
        checks++;
        if (d !== 8'h00) begin
            errors++; $display("FAIL prime_press got %02h want 00", d);
        end
        set_joy(0, 32'h0);
        tick();
        set_joy(0, 32'h0000_0010);
        tick();
        do_read(8'h04, d);
        checks++;
        if (d !== 8'h10) begin
            errors++; $display("FAIL press_bit4 got %02h want 10", d);
        end
    endtask

    task automatic test_clear();
        logic [7:0] d;
        set_joy(2, 32'h1);
        tick();
        do_read(8'h24, d);
        checks++;
        if (d !== 8'h01) begin
            errors++; $display("FAIL p2_press0 got %02h want 01", d);
        end
        set_joy(2, 32'h3);
        cpu_addr = 8'h20;
        cpu_clr  = 1;
        tick();
        do_read(8'h24, d);
        checks++;
        if (d !== 8'h02) begin
            errors++; $display("FAIL clr_edge got %02h want 02", d);
        end
        cpu_addr = 8'h70;
        cpu_clr  = 1;
        tick();
        do_read(8'h24, d);
        checks++;
        if (d !== 8'h02) begin
            errors++; $display("FAIL clr_oob got %02h want 02", d);
        end
        set_joy(2, 32'h7);
        do_read(8'h24, d);            // press lands in the read cycle
        checks++;
        if (d !== 8'h02) begin
            errors++; $display("FAIL press_race got %02h want 02", d);
        end
        do_read(8'h24, d);
        checks++;
        if (d !== 8'h06) begin
            errors++; $display("FAIL press_after got %02h want 06", d);
        end
    endtask

    task automatic test_spinner();
        logic [7:0] d;
        logic [7:0] lo, hi;
        spin_event(1, 8'h7F); tick();
        spin_event(1, 8'h7F); tick();
        spin_event(1, 8'h02); tick();
        do_read(8'h1A, lo);
        do_read(8'h1B, hi);
        checks++;
        if ({hi, lo} !== 16'h0100) begin
            errors++; $display("FAIL acc_0100 got %02h%02h want 0100", hi, lo);
        end
        spin_event(1, 8'hFF); tick();  // acc -> 0x00FF
        do_read(8'h1B, d);
        checks++;
        if (d !== 8'h01) begin
            errors++; $display("FAIL shadow_hold got %02h want 01", d);
        end
        spin_event(1, 8'h80); tick();
        spin_event(1, 8'h80); tick();  // 0x00FF - 0x100 -> 0xFFFF
        do_read(8'h1A, lo);
        do_read(8'h1B, hi);
        checks++;
        if ({hi, lo} !== 16'hFFFF) begin
            errors++; $display("FAIL acc_wrap_dn got %02h%02h want ffff", hi, lo);
        end
        spin_event(1, 8'h01); tick();
        do_read(8'h1A, lo);
        do_read(8'h1B, hi);
        checks++;
        if ({hi, lo} !== 16'h0000) begin
            errors++; $display("FAIL acc_wrap_up got %02h%02h want 0000", hi, lo);
        end
    endtask

    task automatic test_snapshot();
        logic [7:0] d;
        analog_l[0 +: 16] = 16'h80F0;
        snap = 1;
        tick();
        analog_l[0 +: 16] = 16'h1111;
        tick();
        do_read(8'h08, d);
        checks++;
        if (d !== 8'hF0) begin
            errors++; $display("FAIL snap_x got %02h want f0", d);
        end
        do_read(8'h09, d);
        checks++;
        if (d !== 8'h80) begin
            errors++; $display("FAIL snap_y got %02h want 80", d);
        end
        do_read(8'h00, d);
        checks++;
        if (d !== 8'h10) begin
            errors++; $display("FAIL snap_joy got %02h want 10", d);
        end
        snap = 1;
        do_read(8'h08, d);            // snap in the read cycle
        checks++;
        if (d !== 8'hF0) begin
            errors++; $display("FAIL snap_race got %02h want f0", d);
        end
        do_read(8'h08, d);
        checks++;
        if (d !== 8'h11) begin
            errors++; $display("FAIL snap_new got %02h want 11", d);
        end
    endtask

    task automatic test_regs();
        logic [7:0] d;
        do_read(8'h70, d);
        checks++;
        if (cpu_valid !== 1'b1 || d !== 8'h00) begin
            errors++; $display("FAIL oob_read got v=%b d=%02h want v=1 d=00", cpu_valid, d);
        end
        tick();
        checks++;
        if (cpu_valid !== 1'b0 || cpu_dout !== 8'h00) begin
            errors++; $display("FAIL valid_pulse got v=%b d=%02h want v=0 d=00", cpu_valid, cpu_dout);
        end
        do_read(8'h0E, d);
        checks++;
        if (d !== 8'h06) begin
            errors++; $display("FAIL nplayers got %02h want 06", d);
        end
        do_read(8'h3F, d);
        checks++;
        if (d !== 8'h04) begin
            errors++; $display("FAIL joybytes got %02h want 04", d);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 3) == 0) set_joy(p, $urandom());
                if ($urandom_range(0, 2) == 0) spin_event(p, 8'($urandom()));
                if ($urandom_range(0, 7) == 0) analog_l[p*16 +: 16] = 16'($urandom());
            end
            snap     = ($urandom_range(0, 9) == 0);
            cpu_addr = {1'b0, 3'($urandom_range(0, 7)), 4'($urandom())};
            cpu_rd   = ($urandom_range(0, 7) != 0);
            cpu_clr  = ($urandom_range(0, 11) == 0);
            tick();
            checks++;
            if (cpu_valid !== m_valid || cpu_dout !== m_dout) begin
                errors++;
                $display("FAIL rand_read[%0d] got v=%b d=%02h want v=%b d=%02h",
                         i, cpu_valid, cpu_dout, m_valid, m_dout);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        for (int p = 0; p < NP; p++) set_joy(p, $urandom() | 32'h1);
        cpu_addr = 8'h04;
        cpu_rd   = 1;
        reset    = 1;
        tick();
        checks++;
        if (cpu_valid !== 1'b0 || cpu_dout !== 8'h00) begin
            errors++; $display("FAIL rst_drop got v=%b d=%02h want v=0 d=00", cpu_valid, cpu_dout);
        end
        reset = 0;
        tick();
        for (int p = 0; p < NP; p++) begin
            for (int r = 0; r < 14; r++) begin
                do_read({4'(p), 4'(r)}, d);
                checks++;
                if (d !== 8'h00) begin
                    errors++; $display("FAIL rst_clear p%0d r%0d got %02h want 00", p, r, d);
                end
            end
        end
    endtask

    initial begin
        reset    = 1;
        snap     = 0;
        joystick = '0;
        analog_l = '0;
        spinner  = '0;
        cpu_addr = 8'h00;
        cpu_rd   = 0;
        cpu_clr  = 0;
        test_reset();
        test_clear();
        test_spinner();
        test_snapshot();
        test_regs();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
